conv_result_sink: RTL and testbench
===================================

Name: conv_result_sink

Overview:
Capture end of the convolution datapath. It watches the done_conv strobe and result bus of the convolution top and samples each result a fixed number of cycles after the strobe's rising edge. Results are written sequentially into an internal 128x128 result buffer. Once the frame is complete, the buffer is read back through a registered read port for checking or export.

Parameters:
DATA_W, 20, result word width
IMG_W, 128, output image width in pixels
IMG_H, 128, output image height in pixels
ADDR_W, 14, buffer address width; 2^ADDR_W must be >= IMG_W*IMG_H
SAMPLE_DLY, 2, clock cycles from detected done_conv rise to result sampling; legal range 1..7

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level; arms capture when sampled high in IDLE or DONE
done_conv  in  1  convolution-complete strobe from the top FSM; may be held high more than one cycle
result  in  DATA_W  convolution result, valid SAMPLE_DLY cycles after the done_conv rise
rd_en  in  1  readback request, one word per cycle
rd_addr  in  ADDR_W  readback address
rd_data  out  DATA_W  readback word, registered
rd_valid  out  1  rd_data valid strobe
wr_count  out  ADDR_W+1  number of results captured in the current frame
busy  out  1  high in ARMED or SAMPLE
frame_done  out  1  high in DONE
overflow  out  1  sticky: a strobe was missed or arrived after the frame was full

Behaviour:
- Reset values: rd_data=0, rd_valid=0, wr_count=0, busy=0, frame_done=0, overflow=0, state=IDLE, delay counter=0, done_conv edge register=0. Buffer contents are not reset.
- Edge detect: done_q is a registered copy of done_conv. A rise is the cycle where done_conv=1 and done_q=0. Only rises count; a held-high strobe counts once.
- FSM:
  - IDLE: start=1 -> ARMED; wr_count:=0; overflow:=0.
  - ARMED: rise -> SAMPLE; dly:=SAMPLE_DLY-1.
  - SAMPLE: if dly!=0, dly decrements. When dly==0: mem[wr_count]:=result; wr_count increments. If the new wr_count equals IMG_W*IMG_H, go to DONE; otherwise go to ARMED.
  - DONE: start=1 -> ARMED; wr_count:=0; overflow:=0.
- Sampling latency: the result is written on the clock edge exactly SAMPLE_DLY cycles after the edge where the rise is seen. SAMPLE_DLY=1 writes on the next edge.
- A rise while in SAMPLE is not queued: set overflow, and the in-progress sample completes normally.
- A rise while in DONE: set overflow, no write, wr_count is held.
- A rise in the same cycle that SAMPLE completes with the frame not full: it is taken as a new capture (go directly to SAMPLE), not an overflow.
- start is ignored while in ARMED or SAMPLE.
- X handling: none in RTL. Writes happen only on strobe-driven samples, so pre-start garbage is never stored.
- Readback: rd_en=1 in cycle N gives rd_data=mem[rd_addr] and rd_valid=1 in cycle N+1. With rd_en=0, rd_valid=0 and rd_data holds its last value.
- Readback is allowed in any state. A read of the address being written in the same cycle returns the old word (read-before-write).
- rd_addr >= IMG_W*IMG_H returns 0 with rd_valid=1.
- wr_count is width ADDR_W+1 so that it can reach IMG_W*IMG_H; the write address is wr_count[ADDR_W-1:0].
- Reset asserted mid-frame returns the block to IDLE immediately (asynchronous). Partial buffer data is kept but not valid; wr_count reads 0.
- Buffer inference: a single write port and a single registered read port, suitable for block RAM.

Test Plan:
- Reset and arm: hold rst_n=0 for 3 cycles, release, pulse start -> busy=1, wr_count=0, frame_done=0, overflow=0.
- Single capture, SAMPLE_DLY=2: done_conv rises at cycle 10, result=20'h0ABCD from cycle 11 -> written at cycle 12; wr_count=1; rd_en with rd_addr=0 gives rd_data=20'h0ABCD and rd_valid one cycle later.
- Held strobe: done_conv high for 5 cycles -> exactly one write, wr_count increments by 1.
- Full frame: 16384 strobes with result=index -> frame_done=1, wr_count=16384, busy=0. Readback of addresses 0, 127, 8191, 16383 returns the same values.
- Overflow cases: a rise during SAMPLE -> overflow=1 and only 1 word written. A 16385th strobe after the frame is full -> overflow=1, wr_count stays 16384. Asserting start in DONE clears overflow.
- Reset mid-frame: rst_n=0 after 100 captures -> immediately wr_count=0, busy=0, state IDLE. A re-armed capture then writes to address 0.

Source files
------------

// File: rtl/conv_result_sink.sv
// Captures convolution results into a frame buffer, one word per done_conv rise,
// and serves a registered readback port once (or while) the frame is filled.
module conv_result_sink #(
  parameter int DATA_W     = 20,
  parameter int IMG_W      = 128,
  parameter int IMG_H      = 128,
  parameter int ADDR_W     = 14,
  parameter int SAMPLE_DLY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              done_conv,
  input  logic [DATA_W-1:0] result,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  localparam int              FRAME    = IMG_W * IMG_H;
  localparam logic [ADDR_W:0] FRAME_N  = (ADDR_W + 1)'(FRAME);
  localparam logic [2:0]      DLY_INIT = 3'(SAMPLE_DLY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [2:0]        dly;
  logic              done_q;
  logic              rise;
  logic              we;
  logic              rd_in_range;
  logic [ADDR_W:0]   wr_next;
  logic [DATA_W-1:0] mem [0:FRAME-1];

  assign rise        = done_conv & ~done_q;
  assign we          = (state == SAMPLE) && (dly == 3'd0);
  assign wr_next     = wr_count + (ADDR_W + 1)'(1);
  assign rd_in_range = ({1'b0, rd_addr} < FRAME_N);
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dly        <= 3'd0;
      done_q     <= 1'b0;
      wr_count   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done_q <= done_conv;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= ARMED;
            busy       <= 1'b1;
            frame_done <= 1'b0;
            wr_count   <= '0;
            overflow   <= 1'b0;
          end else if (rise && state == DONE) begin
            overflow <= 1'b1;
          end
        end
        ARMED: begin
          if (rise) begin
            state <= SAMPLE;
            dly   <= DLY_INIT;
          end
        end
        SAMPLE: begin
          if (dly != 3'd0) begin
            dly <= dly - 3'd1;
            // A strobe arriving mid-sample is dropped, never queued.
            if (rise) overflow <= 1'b1;
          end else begin
            wr_count <= wr_next;
            if (wr_next == FRAME_N) begin
              state      <= DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              if (rise) overflow <= 1'b1;
            end else if (rise) begin
              dly <= DLY_INIT;
            end else begin
              state <= ARMED;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_count[ADDR_W-1:0]] <= result;
  end

  // Readback: rd_en is a per-cycle request with no backpressure; rd_valid
  // pulses exactly one cycle later with rd_data, which then holds until the
  // next request. Same-cycle write to the read address returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_conv_result_sink.sv
// Bench for conv_result_sink: default instance plus a SAMPLE_DLY=4 instance
// used to exercise a strobe arriving while a sample is still pending.
module tb_conv_result_sink;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 14;
  localparam int FRAME  = 16384;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              done_conv = 1'b0;
  logic [DATA_W-1:0] result = '0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;

  logic [DATA_W-1:0] rd_data, rd_data_s;
  logic              rd_valid, rd_valid_s;
  logic [ADDR_W:0]   wr_count, wr_count_s;
  logic              busy, busy_s, frame_done, frame_done_s, overflow, overflow_s;
  logic [1:0]        dbg_state, dbg_state_s;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_w;

  conv_result_sink dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done_conv(done_conv), .result(result),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_count(wr_count), .busy(busy), .frame_done(frame_done), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  conv_result_sink #(.SAMPLE_DLY(4)) dut_slow (
    .clk(clk), .rst_n(rst_n), .start(start), .done_conv(done_conv), .result(result),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s), .rd_valid(rd_valid_s),
    .wr_count(wr_count_s), .busy(busy_s), .frame_done(frame_done_s), .overflow(overflow_s),
    .dbg_state(dbg_state_s)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks (inputs change on negedge) ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic capture(input logic [DATA_W-1:0] val);
    done_conv = 1'b1;
    result    = val;
    tick(1);
    done_conv = 1'b0;
    tick(3);
  endtask

  task automatic drive_read(input logic [ADDR_W-1:0] addr);
    rd_en   = 1'b1;
    rd_addr = addr;
    tick(1);
    rd_en   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if (wr_count !== '0 || busy !== 1'b0 || frame_done !== 1'b0 || overflow !== 1'b0 ||
        rd_valid !== 1'b0 || rd_data !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: wr_count=%0d busy=%b frame_done=%b overflow=%b rd_valid=%b rd_data=%h state=%0d, expected all 0",
               wr_count, busy, frame_done, overflow, rd_valid, rd_data, dbg_state);
    end
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || wr_count !== '0 || frame_done !== 1'b0 || overflow !== 1'b0 || dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL arm: busy=%b wr_count=%0d frame_done=%b overflow=%b state=%0d, expected 1 0 0 0 1",
               busy, wr_count, frame_done, overflow, dbg_state);
    end
  endtask

  task automatic test_single_capture();
    done_conv = 1'b1;
    tick(1);
    done_conv = 1'b0;
    result    = 20'h0ABCD;
    tick(1);
    checks++;
    if (wr_count !== 15'd0) begin
      errors++;
      $display("FAIL latency_early: wr_count=%0d, expected 0 one cycle after rise", wr_count);
    end
    tick(1);
    checks++;
    if (wr_count !== 15'd1 || dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL latency_write: wr_count=%0d state=%0d, expected 1 and 1", wr_count, dbg_state);
    end
    exp_q.push_back(20'h0ABCD);
    drive_read(14'd0);
    exp_w = exp_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_w) begin
      errors++;
      $display("FAIL single_read: rd_valid=%b rd_data=%h, expected 1 %h", rd_valid, rd_data, exp_w);
    end
    tick(1);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== exp_w) begin
      errors++;
      $display("FAIL read_hold: rd_valid=%b rd_data=%h, expected 0 %h", rd_valid, rd_data, exp_w);
    end
  endtask

  task automatic test_held_strobe();
    result    = 20'h12345;
    done_conv = 1'b1;
    tick(5);
    done_conv = 1'b0;
    tick(3);
    checks++;
    if (wr_count !== 15'd2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL held_strobe: wr_count=%0d overflow=%b, expected 2 0", wr_count, overflow);
    end
    exp_q.push_back(20'h12345);
    drive_read(14'd1);
    exp_w = exp_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== exp_w) begin
      errors++;
      $display("FAIL held_read: rd_valid=%b rd_data=%h, expected 1 %h", rd_valid, rd_data, exp_w);
    end
  endtask

  // Rises two cycles apart: a new capture for SAMPLE_DLY=2, an overflow for SAMPLE_DLY=4.
  task automatic test_back_to_back();
    do_reset();
    pulse_start();
    done_conv = 1'b1;
    result    = 20'h0000A;
    tick(1);
    done_conv = 1'b0;
    tick(1);
    done_conv = 1'b1;
    tick(1);
    done_conv = 1'b0;
    result    = 20'h0000B;
    tick(4);
    checks++;
    if (wr_count !== 15'd2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fast: wr_count=%0d overflow=%b, expected 2 0", wr_count, overflow);
    end
    checks++;
    if (wr_count_s !== 15'd1 || overflow_s !== 1'b1 || busy_s !== 1'b1) begin
      errors++;
      $display("FAIL overflow_in_sample: wr_count=%0d overflow=%b busy=%b, expected 1 1 1",
               wr_count_s, overflow_s, busy_s);
    end
    exp_q.push_back(20'h0000A);
    exp_q.push_back(20'h0000B);
    for (int i = 0; i < 2; i++) begin
      drive_read(ADDR_W'(i));
      exp_w = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_w) begin
        errors++;
        $display("FAIL b2b_read%0d: rd_valid=%b rd_data=%h, expected 1 %h", i, rd_valid, rd_data, exp_w);
      end
    end
    drive_read(14'd0);
    checks++;
    if (rd_valid_s !== 1'b1 || rd_data_s !== 20'h0000B) begin
      errors++;
      $display("FAIL slow_read: rd_valid=%b rd_data=%h, expected 1 0000b", rd_valid_s, rd_data_s);
    end
  endtask

  task automatic test_full_frame();
    int addrs[4] = '{0, 127, 8191, 16383};
    do_reset();
    pulse_start();
    for (int k = 0; k < FRAME; k++) begin
      done_conv = 1'b1;
      tick(1);
      done_conv = 1'b0;
      result    = DATA_W'(k);
      tick(1);
    end
    tick(3);
    checks++;
    if (frame_done !== 1'b1 || wr_count !== 15'd16384 || busy !== 1'b0 ||
        overflow !== 1'b0 || dbg_state !== 2'd3) begin
      errors++;
      $display("FAIL full_frame: frame_done=%b wr_count=%0d busy=%b overflow=%b state=%0d, expected 1 16384 0 0 3",
               frame_done, wr_count, busy, overflow, dbg_state);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(DATA_W'(addrs[i]));
      drive_read(ADDR_W'(addrs[i]));
      exp_w = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_w) begin
        errors++;
        $display("FAIL frame_read[%0d]: rd_valid=%b rd_data=%h, expected 1 %h", addrs[i], rd_valid, rd_data, exp_w);
      end
    end
  endtask

  task automatic test_overflow_full();
    capture(20'hFFFFF);
    checks++;
    if (overflow !== 1'b1 || wr_count !== 15'd16384 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL overflow_full: overflow=%b wr_count=%0d frame_done=%b, expected 1 16384 1",
               overflow, wr_count, frame_done);
    end
    exp_q.push_back(20'h00000);
    drive_read(14'd0);
    exp_w = exp_q.pop_front();
    checks++;
    if (rd_data !== exp_w) begin
      errors++;
      $display("FAIL overflow_no_write: rd_data=%h, expected %h", rd_data, exp_w);
    end
    pulse_start();
    checks++;
    if (overflow !== 1'b0 || wr_count !== 15'd0 || busy !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rearm_clear: overflow=%b wr_count=%0d busy=%b frame_done=%b, expected 0 0 1 0",
               overflow, wr_count, busy, frame_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 100; k++) begin
      done_conv = 1'b1;
      tick(1);
      done_conv = 1'b0;
      result    = DATA_W'(k + 20'h00100);
      tick(1);
    end
    tick(2);
    checks++;
    if (wr_count !== 15'd100) begin
      errors++;
      $display("FAIL mid_count: wr_count=%0d, expected 100", wr_count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wr_count !== 15'd0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: wr_count=%0d busy=%b state=%0d, expected 0 0 0", wr_count, busy, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    pulse_start();
    capture(20'h5A5A5);
    exp_q.push_back(20'h5A5A5);
    exp_q.push_back(20'h00101);
    for (int i = 0; i < 2; i++) begin
      drive_read(ADDR_W'(i));
      exp_w = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_w) begin
        errors++;
        $display("FAIL post_reset_read%0d: rd_valid=%b rd_data=%h, expected 1 %h", i, rd_valid, rd_data, exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_held_strobe();
    test_back_to_back();
    test_full_frame();
    test_overflow_full();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
